// File: rtl/stepper_move_ctrl.sv
// Move sequencer for a 4-wire stepper: accepts a move over valid/ready, paces steps with a
// prescaler, drives the coils from an 8-entry phase table, holds torque, then de-energizes.
module stepper_move_ctrl #(
  parameter int unsigned STEP_DIV    = 12000,
  parameter int unsigned HOLD_CYCLES = 120000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic             cmd_half,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pos,
  output logic             B2,
  output logic             B1,
  output logic             A2,
  output logic             A1
);

  localparam int unsigned PRE_W  = $clog2(STEP_DIV + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(STEP_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Coil pattern {B2,B1,A2,A1}; even index = wave drive, odd index = two-phase drive.
  function automatic logic [3:0] phase_coils(input logic [2:0] idx);
    logic [3:0] c;
    case (idx)
      3'd0:    c = 4'b0001;
      3'd1:    c = 4'b0101;
      3'd2:    c = 4'b0100;
      3'd3:    c = 4'b0110;
      3'd4:    c = 4'b0010;
      3'd5:    c = 4'b1010;
      3'd6:    c = 4'b1000;
      3'd7:    c = 4'b1001;
      default: c = 4'b0000;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] next_idx(input logic [2:0] idx, input logic dir,
                                          input logic half);
    logic [2:0] stride;
    stride = half ? 3'd1 : 3'd2;
    return dir ? (idx + stride) : (idx - stride);
  endfunction

  state_t             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0]   pos_q, pos_d;
  logic               dir_q, dir_d;
  logic               half_q, half_d;
  logic [3:0]         coils_q, coils_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               accept_s;
  logic               tc_s;
  logic [2:0]         nidx_s;

  assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_HOLD);
  assign accept_s  = cmd_valid && cmd_ready;
  assign tc_s      = (pre_q == PRE_LAST);
  assign nidx_s    = next_idx(idx_q, dir_q, half_q);

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    pre_d   = pre_q;
    hold_d  = hold_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    half_d  = half_q;
    coils_d = coils_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        coils_d = 4'b0000;
        if (accept_s) begin
          if (cmd_steps == {CNT_W{1'b0}}) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            dir_d   = cmd_dir;
            half_d  = cmd_half;
            rem_d   = cmd_steps;
            pre_d   = {PRE_W{1'b0}};
            coils_d = phase_coils(idx_q);
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (tc_s) begin
          idx_d   = nidx_s;
          pos_d   = dir_q ? (pos_q + CNT_W'(1)) : (pos_q - CNT_W'(1));
          rem_d   = rem_q - CNT_W'(1);
          pre_d   = {PRE_W{1'b0}};
          coils_d = phase_coils(nidx_s);
        end else begin
          pre_d   = pre_q + PRE_W'(1);
        end
        // A step coinciding with abort still lands; abort only cuts the remaining count.
        if (abort || (tc_s && (rem_q == CNT_W'(1)))) begin
          rem_d   = {CNT_W{1'b0}};
          hold_d  = {HOLD_W{1'b0}};
          state_d = ST_HOLD;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_HOLD: begin
        if (accept_s) begin
          done_d = 1'b1;
          if (cmd_steps == {CNT_W{1'b0}}) begin
            coils_d = 4'b0000;
            state_d = ST_IDLE;
          end else begin
            dir_d   = cmd_dir;
            half_d  = cmd_half;
            rem_d   = cmd_steps;
            pre_d   = {PRE_W{1'b0}};
            coils_d = phase_coils(idx_q);
            state_d = ST_RUN;
          end
        end else if (hold_q == HOLD_LAST) begin
          coils_d = 4'b0000;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          hold_d  = hold_q + HOLD_W'(1);
          state_d = ST_HOLD;
        end
      end

      default: begin
        coils_d = 4'b0000;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      rem_q   <= {CNT_W{1'b0}};
      pre_q   <= {PRE_W{1'b0}};
      hold_q  <= {HOLD_W{1'b0}};
      pos_q   <= {CNT_W{1'b0}};
      dir_q   <= 1'b0;
      half_q  <= 1'b0;
      coils_q <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      pre_q   <= pre_d;
      hold_q  <= hold_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      half_q  <= half_d;
      coils_q <= coils_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign pos  = pos_q;
  assign {B2, B1, A2, A1} = coils_q;

endmodule
